// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// N_TICKS is the single oversampling value shared with the baud-rate generator.
package uart_pkg;

    localparam int N_TICKS     = 16;
    localparam int N_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops load RESET_VALUE on a synchronous active-low reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            meta <= RESET_VALUE;
            o_q  <= RESET_VALUE;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start bit checked at mid-bit, data and stop
// bits sampled at their centres, with registered done / framing-error strobes.
module uart_rx #(
    parameter int N_DATA_BITS = uart_pkg::N_DATA_BITS,
    parameter int N_TICKS     = uart_pkg::N_TICKS
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_tick,
    input  logic                   i_rx,
    output logic [N_DATA_BITS-1:0] o_data,
    output logic                   o_rx_done,
    output logic                   o_frame_error
);

    import uart_pkg::*;

    localparam int TW = $clog2(N_TICKS);
    localparam int BW = $clog2(N_DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(N_TICKS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_DATA_BITS - 1);

    logic                   rx_s;
    rx_state_t              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [N_DATA_BITS-1:0] shift_q, shift_d;
    logic [N_DATA_BITS-1:0] data_q, data_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;

    sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_q == TICK_HALF) begin
                        if (!rx_s) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        // LSB-first line order: right shift puts the first bit at bit 0.
                        shift_d = {rx_s, shift_q[N_DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            BREAK: begin
                // A line held low must return high before a new frame can start.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data        = data_q;
    assign o_rx_done     = done_q;
    assign o_frame_error = ferr_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. It consumes the 16x oversampling tick from the baud-rate generator and the asynchronous RX line. It validates the start bit at mid-bit and samples each data bit at its centre. It presents each received byte with a one-cycle done strobe, or flags a framing error, to the downstream rx FIFO / interface logic.

## Interface
Parameters:
- N_DATA_BITS, 8, data bits per frame, LSB first.
- N_TICKS, 16, oversampling ticks per bit; must match the baud-rate generator.

Ports:
- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_tick  in  1  one-cycle oversampling strobe from the baud-rate generator.
- i_rx  in  1  asynchronous serial line; idles high.
- o_data  out  N_DATA_BITS  last correctly framed word.
- o_rx_done  out  1  one-cycle pulse; o_data is valid from this cycle.
- o_frame_error  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- i_rx passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- tick_cnt (log2 N_TICKS bits) and bit_cnt (log2 N_DATA_BITS bits) advance only on cycles with i_tick=1. A shift register holds the assembling word.
- States:
  - IDLE: when rx_s=0, clear tick_cnt and go to START. Ticks are ignored while in IDLE.
  - START: on each tick, if tick_cnt==N_TICKS/2-1:
    - rx_s=0: clear tick_cnt and bit_cnt, go to DATA.
    - rx_s=1: glitch; go to IDLE with no output.
    - Otherwise increment tick_cnt.
  - DATA: on a tick with tick_cnt==N_TICKS-1:
    - Shift rx_s in at the MSB and shift the register right, so the first bit lands at the LSB.
    - Clear tick_cnt.
    - If bit_cnt==N_DATA_BITS-1, go to STOP; else increment bit_cnt.
  - STOP: on a tick with tick_cnt==N_TICKS-1:
    - rx_s=1: load o_data from the shift register, pulse o_rx_done, go to IDLE.
    - rx_s=0: pulse o_frame_error, leave o_data unchanged, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Sampling therefore occurs at mid-bit (±1 tick) for the start bit, every data bit and the stop bit.
- o_rx_done and o_frame_error are never high in the same cycle.
- o_data holds its value until the next good frame.

## Timing
- Reset (i_reset=0 at a clock edge): state=IDLE, counters=0, shift register=0, o_data=0, o_rx_done=0, o_frame_error=0, synchronizer flops=1.
- Reset mid-frame aborts with no strobe.
- Synchronizer latency: 2 clocks from i_rx to rx_s.
- Strobes are registered. o_rx_done / o_frame_error go high in the cycle after the clock edge that samples the stop bit, and last exactly one cycle.
- Line-to-strobe latency from the start-bit falling edge: about (N_TICKS/2 + (N_DATA_BITS+1)·N_TICKS) ticks, plus 2–3 clocks.
- Back-to-back frames: a start bit immediately after a 1-bit stop is accepted. IDLE is re-entered half a bit before the stop bit ends.
- i_tick held low: the FSM may enter START but never advances further.
- i_rx changing in the same cycle as i_tick needs no special handling; the sampled value is rx_s at that edge.

## Structure
- Shared package uart_pkg holds:
  - N_TICKS=16 (single source shared with the baud-rate generator);
  - the default N_DATA_BITS;
  - the state enumeration localparams IDLE/START/DATA/STOP/BREAK, binary encoded, 3 bits.
- Sub-module sync_2ff (generic reset value parameter) for the RX input synchronizer; everything else stays in uart_rx.

## Test plan
- Stimulus setup: i_tick every 4 clocks, 64 clocks per bit.
- Good frame: send 0xA5 with stop=1 -> o_data=0xA5; exactly one o_rx_done pulse; o_frame_error stays 0.
- Start glitch: hold rx low for 3 ticks, then high -> no strobe and FSM returns to IDLE. A following frame 0x3C -> o_data=0x3C.
- Framing error: send 0x55 with stop=0, then hold low 40 ticks -> one o_frame_error pulse, o_data keeps the prior value, no further strobes. Release and send 0x0F -> o_data=0x0F.
- Reset mid-frame: drive i_reset=0 during data bit 3 -> all outputs 0, no strobe. After release, a frame 0xFF -> o_data=0xFF.
- Back-to-back: send 0x00 then 0xFF with single stop bits -> two o_rx_done pulses with o_data 0x00 then 0xFF.
- Tick starvation: i_tick=0 and send 0x81 -> no strobe and o_data unchanged.
